ifetch_unit: RTL and testbench

- Instruction fetch front-end for the RISC-V core; the producer side of the instruction decode interface.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Buffers returned words in a small FIFO and presents the head instruction, its PC and the pre-sliced decode fields (op, funct3, funct7b5) to the controller.
- Takes control-flow redirects (branch/jump resolved from PCSrc) back from the datapath.

---
 rtl/ifetch_unit.sv | 161 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the PC, fetches one word at a time and queues results for decode.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky flag and halt fetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        fetch_misaligned
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, fill;
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

  logic        accept, push, pop, flush;
  logic        blocked, blocked_next;
  logic [31:0] target;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign target           = redirect_pc;
  assign mis_d            = mis_q | (redirect & (redirect_pc[1:0] != 2'b00));
  assign blocked          = mis_q;
  assign blocked_next     = mis_d;
  assign fetch_misaligned = mis_q;
`else
  assign target           = redirect_pc & 32'hFFFF_FFFC;
  assign blocked          = 1'b0;
  assign blocked_next     = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign accept      = imem_req & imem_ready;
  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7b5    = instr[30];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    push     = 1'b0;
    pop      = instr_valid & instr_ready;
    flush    = 1'b0;
    fill     = count_q;

    case (state_q)
      S_IDLE: begin
        if (!blocked && count_q < DEPTH_C) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) drop_d = 1'b0;
          else        push   = 1'b1;
          fill    = count_q + CW'(push) - CW'(pop);
          state_d = (!blocked && fill < DEPTH_C) ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A response landing in the redirect cycle completes the old request, so nothing is left to drop.
    if (redirect) begin
      pc_d  = target;
      flush = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      if (accept || (state_q == S_WAIT && !imem_rvalid)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = blocked_next ? S_IDLE : S_FETCH;
      end
    end

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      mis_q    <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a single-outstanding instruction memory responder.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        fetch_misaligned;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic        hold   = 1'b0;
  logic        pend   = 1'b0;
  logic [31:0] pend_a = 32'h0;
  logic [31:0] acc_log [$];

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .fetch_misaligned(fetch_misaligned)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
  endfunction

  // Memory: samples acceptance at the edge, answers one cycle later unless held.
  always @(posedge clk) begin : mem_model
    logic        acc;
    logic [31:0] a;
    acc = imem_req & imem_ready;
    a   = imem_addr;
    #1;
    if (acc) begin
      pend   = 1'b1;
      pend_a = a;
      acc_log.push_back(a);
    end
    if (pend && !hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_a);
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(imem_req), 32'h1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(instr_valid), 32'h1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'h0);
    chk({tag, "_addr"},  imem_addr,        32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr,            32'h0);
    chk({tag, "_pc"},    instr_pc,         32'h0);
    chk({tag, "_op"},    32'(op),          32'h0);
    chk({tag, "_f3"},    32'(funct3),      32'h0);
    chk({tag, "_f7b5"},  32'(funct7b5),    32'h0);
    chk({tag, "_mis"},   32'(fetch_misaligned), 32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    step(2);
    chk_reset("rst");

    // First fetch from RESET_PC
    reset = 1'b0;
    step(1);
    chk("first_req",  32'(imem_req), 32'h1);
    chk("first_addr", imem_addr,     32'h0);
    step(2);
    chk("first_valid", 32'(instr_valid), 32'h1);
    chk("first_instr", instr,            32'h0050_0093);
    chk("first_pc",    instr_pc,         32'h0);
    chk("first_op",    32'(op),          32'h13);
    chk("first_f3",    32'(funct3),      32'h0);
    chk("first_f7b5",  32'(funct7b5),    32'h0);
    chk("second_addr", imem_addr,        32'h4);

    // Backpressure: FIFO fills after two requests, fetch stops
    step(6);
    chk("full_req",   32'(imem_req),       32'h0);
    chk("full_nacc",  32'(acc_log.size()), 32'h2);
    chk("full_acc1",  acc_log[1],          32'h4);
    chk("full_head",  instr_pc,            32'h0);

    // Drain in order, fetch resumes at 8
    instr_ready = 1'b1;
    step(1);
    chk("pop1_pc",    instr_pc,         32'h4);
    chk("pop1_instr", instr,            32'h0000_0413);
    chk("pop1_valid", 32'(instr_valid), 32'h1);
    step(1);
    chk("pop2_valid", 32'(instr_valid), 32'h0);
    chk("resume_req", 32'(imem_req),    32'h1);
    chk("resume_addr", imem_addr,       32'h8);
    instr_ready = 1'b0;
    hold        = 1'b1;

    // Redirect while the fetch of 8 is outstanding
    step(1);
    chk("wait_req",  32'(imem_req),       32'h0);
    chk("wait_nacc", 32'(acc_log.size()), 32'h3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step(1);
    redirect = 1'b0;
    hold     = 1'b0;
    chk("rd_valid", 32'(instr_valid), 32'h0);
    chk("rd_req",   32'(imem_req),    32'h0);
    wait_req("rd_req_to");
    chk("rd_addr",  imem_addr,             32'h100);
    chk("rd_nacc",  32'(acc_log.size()),   32'h3);
    wait_valid("rd_valid_to");
    chk("rd_pc",    instr_pc,              32'h100);
    chk("rd_instr", instr,                 32'h0001_0013);

    // Redirect coinciding with acceptance and pop
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1'b1;
    step(1);
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("co_valid", 32'(instr_valid),             32'h0);
    chk("co_req",   32'(imem_req),                32'h0);
    chk("co_acc",   acc_log[acc_log.size() - 1],  32'h104);
    step(1);
    chk("co_req2",  32'(imem_req), 32'h1);
    chk("co_addr",  imem_addr,     32'h200);
    wait_valid("co_valid_to");
    chk("co_pc",    instr_pc,      32'h200);
    chk("co_instr", instr,         32'h0002_0013);

    // PC wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0;
    wait_req("wrap_req_to");
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid_to");
    chk("wrap_pc",    instr_pc,      32'hFFFF_FFFC);
    chk("wrap_instr", instr,         32'hFFFF_FC13);
    chk("wrap_op",    32'(op),       32'h13);
    chk("wrap_f3",    32'(funct3),   32'h7);
    chk("wrap_f7b5",  32'(funct7b5), 32'h1);
    chk("wrap_req",   32'(imem_req), 32'h1);
    chk("wrap_addr1", imem_addr,     32'h0);

    // Reset while a request is outstanding; its late response must be ignored
    hold = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    chk_reset("mrst");
    reset = 1'b0;
    hold  = 1'b0;
    step(1);
    chk("late_req",    32'(imem_req),    32'h1);
    chk("late_valid0", 32'(instr_valid), 32'h0);
    step(1);
    chk("late_valid1", 32'(instr_valid), 32'h0);
    step(1);
    chk("late_valid2", 32'(instr_valid), 32'h1);
    chk("late_pc",     instr_pc,         32'h0);
    chk("late_instr",  instr,            32'h0050_0093);

    // Misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    step(1);
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("mis_flag",  32'(fetch_misaligned), 32'h1);
    chk("mis_valid", 32'(instr_valid),      32'h0);
    for (int i = 0; i < 6; i++) chk("mis_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("mis_req_hold", 32'(imem_req), 32'h0);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step(1);
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("mis_req_after", 32'(imem_req),         32'h0);
      chk("mis_sticky",    32'(fetch_misaligned), 32'h1);
    end
`else
    chk("mis_flag", 32'(fetch_misaligned), 32'h0);
    wait_req("mis_req_to");
    chk("mis_addr", imem_addr, 32'h100);
    wait_valid("mis_valid_to");
    chk("mis_pc",   instr_pc,  32'h100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
